// File: rtl/sr_pulse_gen_if.sv
// Button/latch-drive bundle for sr_pulse_gen.
// Optional: SR_CONFLICT_CNT_EN adds the conflict_cnt[7:0] signal.
interface sr_pulse_gen_if;
  logic       btn_s;
  logic       btn_r0;
  logic       btn_r1;
  logic       s_out;
  logic       r0_out;
  logic       r1_out;
  logic       busy;
`ifdef SR_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;

  modport master (
    output btn_s, btn_r0, btn_r1,
    input  s_out, r0_out, r1_out, busy, conflict_cnt
  );

  modport slave (
    input  btn_s, btn_r0, btn_r1,
    output s_out, r0_out, r1_out, busy, conflict_cnt
  );
`else
  modport master (
    output btn_s, btn_r0, btn_r1,
    input  s_out, r0_out, r1_out, busy
  );

  modport slave (
    input  btn_s, btn_r0, btn_r1,
    output s_out, r0_out, r1_out, busy
  );
`endif
endinterface

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: synchronise, debounce and edge-detect three push-buttons,
// then arbitrate the presses into registered one-cycle S/R0/R1 pulses with
// a guard cycle between pulses. Reset requests dominate a coincident set.
// Optional: SR_CONFLICT_CNT_EN adds a saturating count of dropped sets.
//
// state | meaning
// IDLE  | waiting for a pending request, arbitrates on this cycle
// SET_P | s_out high for this one cycle
// RST_P | r0_out and/or r1_out high for this one cycle
// GUARD | all outputs low for one cycle before re-arbitration
module sr_pulse_gen #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  sr_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2,
    GUARD = 2'd3
  } state_t;

  // Channel index: 0 = set, 1 = reset 0, 2 = reset 1.
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  logic [2:0]            btn;
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            stable_q, stable_d;
  logic [2:0]            stable_prev_q, stable_prev_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            pend_q, pend_d;
  logic [2:0]            rise;
  logic [2:0]            clr;
  state_t                state_q, state_d;
  logic                  s_out_q, s_out_d;
  logic                  r0_out_q, r0_out_d;
  logic                  r1_out_q, r1_out_d;
`ifdef SR_CONFLICT_CNT_EN
  logic                  conflict_drop;
  logic [7:0]            conflict_cnt_q, conflict_cnt_d;
`endif

  assign btn = {bus.btn_r1, bus.btn_r0, bus.btn_s};

  // Synchroniser, debouncer and rising-edge detect for each channel.
  always_comb begin
    sync1_d       = btn;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    cnt_d         = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise = stable_q & ~stable_prev_q;
  end

  // Arbitration FSM: next state, registered pulse outputs, pending clears.
  always_comb begin
    state_d  = state_q;
    s_out_d  = 1'b0;
    r0_out_d = 1'b0;
    r1_out_d = 1'b0;
    clr      = 3'b000;
`ifdef SR_CONFLICT_CNT_EN
    conflict_drop = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q[1] | pend_q[2]) begin
          state_d  = RST_P;
          r0_out_d = pend_q[1];
          r1_out_d = pend_q[2];
          clr      = pend_q;
`ifdef SR_CONFLICT_CNT_EN
          conflict_drop = pend_q[0];
`endif
        end else if (pend_q[0]) begin
          state_d = SET_P;
          s_out_d = 1'b1;
          clr[0]  = 1'b1;
        end
      end
      SET_P:   state_d = GUARD;
      RST_P:   state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A press detected on the same cycle as a clear is a new request.
    pend_d = (pend_q & ~clr) | rise;
  end

`ifdef SR_CONFLICT_CNT_EN
  // Saturating count of set requests dropped in favour of a reset.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_drop && (conflict_cnt_q != 8'hFF)) begin
      conflict_cnt_d = conflict_cnt_q + 8'd1;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end

  assign bus.conflict_cnt = conflict_cnt_q;
`endif

  // State, channel and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
      pend_q        <= '0;
      state_q       <= IDLE;
      s_out_q       <= 1'b0;
      r0_out_q      <= 1'b0;
      r1_out_q      <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      state_q       <= state_d;
      s_out_q       <= s_out_d;
      r0_out_q      <= r0_out_d;
      r1_out_q      <= r1_out_d;
    end
  end

  assign bus.s_out  = s_out_q;
  assign bus.r0_out = r0_out_q;
  assign bus.r1_out = r1_out_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed testbench for sr_pulse_gen (DB_CYCLES=4).
// Build with +define+SR_CONFLICT_CNT_EN to also check conflict_cnt.
module tb_sr_pulse_gen;

  logic clk;
  logic reset;

  sr_pulse_gen_if bus();

  sr_pulse_gen #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Pulse statistics gathered on the falling edge.
  int s_cnt = 0, r0_cnt = 0, r1_cnt = 0, busy_cnt = 0;
  int overlap_cnt = 0, gap_viol = 0;
  int cyc = 0, last_pulse = -100;

  int b_s, b_r0, b_r1, b_busy;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (bus.s_out)  s_cnt  = s_cnt + 1;
      if (bus.r0_out) r0_cnt = r0_cnt + 1;
      if (bus.r1_out) r1_cnt = r1_cnt + 1;
      if (bus.busy)   busy_cnt = busy_cnt + 1;
      if (bus.s_out && (bus.r0_out || bus.r1_out)) overlap_cnt = overlap_cnt + 1;
      if (bus.s_out || bus.r0_out || bus.r1_out) begin
        if (cyc - last_pulse < 3) gap_viol = gap_viol + 1;
        last_pulse = cyc;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_s = s_cnt; b_r0 = r0_cnt; b_r1 = r1_cnt; b_busy = busy_cnt;
  endtask

  task automatic settle();
    bus.btn_s = 1'b0; bus.btn_r0 = 1'b0; bus.btn_r1 = 1'b0;
    tick(20);
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_s = 1'b0; bus.btn_r0 = 1'b0; bus.btn_r1 = 1'b0;
    tick(3);
    chk("rst_s_out", int'(bus.s_out), 0);
    chk("rst_r0_out", int'(bus.r0_out), 0);
    chk("rst_r1_out", int'(bus.r1_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
`ifdef SR_CONFLICT_CNT_EN
    chk("rst_conflict", int'(bus.conflict_cnt), 0);
`endif
    reset = 1'b0;
    tick(5);

    // 1: clean set press held 20 cycles
    snap();
    bus.btn_s = 1'b1;
    tick(7);
    chk("t1_s_before_edge8", int'(bus.s_out), 0);
    tick(1);
    chk("t1_s_at_edge8", int'(bus.s_out), 1);
    chk("t1_r0_at_edge8", int'(bus.r0_out), 0);
    chk("t1_busy_setp", int'(bus.busy), 1);
    tick(1);
    chk("t1_s_guard", int'(bus.s_out), 0);
    chk("t1_busy_guard", int'(bus.busy), 1);
    tick(1);
    chk("t1_busy_idle", int'(bus.busy), 0);
    tick(10);
    settle();
    chk("t1_s_pulses", s_cnt - b_s, 1);
    chk("t1_r_pulses", (r0_cnt - b_r0) + (r1_cnt - b_r1), 0);
    chk("t1_busy_cycles", busy_cnt - b_busy, 2);

    // 2: bouncing set button, then held
    snap();
    for (int i = 0; i < 3; i++) begin
      bus.btn_s = 1'b1; tick(2);
      bus.btn_s = 1'b0; tick(2);
    end
    tick(10);
    chk("t2_no_pulse_bounce", s_cnt - b_s, 0);
    bus.btn_s = 1'b1;
    tick(7);
    chk("t2_s_before_edge8", int'(bus.s_out), 0);
    tick(1);
    chk("t2_s_at_edge8", int'(bus.s_out), 1);
    tick(12);
    settle();
    chk("t2_s_pulses", s_cnt - b_s, 1);

    // 3: both resets together
    snap();
    bus.btn_r0 = 1'b1; bus.btn_r1 = 1'b1;
    tick(8);
    chk("t3_r0_at_edge8", int'(bus.r0_out), 1);
    chk("t3_r1_at_edge8", int'(bus.r1_out), 1);
    chk("t3_s_at_edge8", int'(bus.s_out), 0);
    tick(1);
    chk("t3_r0_guard", int'(bus.r0_out), 0);
    settle();
    chk("t3_r0_pulses", r0_cnt - b_r0, 1);
    chk("t3_r1_pulses", r1_cnt - b_r1, 1);
    chk("t3_s_pulses", s_cnt - b_s, 0);

    // 4: set and reset together, reset wins
    snap();
    bus.btn_s = 1'b1; bus.btn_r0 = 1'b1;
    tick(8);
    chk("t4_r0_at_edge8", int'(bus.r0_out), 1);
    chk("t4_s_at_edge8", int'(bus.s_out), 0);
    settle();
    chk("t4_s_pulses", s_cnt - b_s, 0);
    chk("t4_r0_pulses", r0_cnt - b_r0, 1);
`ifdef SR_CONFLICT_CNT_EN
    chk("t4_conflict", int'(bus.conflict_cnt), 1);
`endif

    // 5: set debounced while RST_P is active
    snap();
    bus.btn_r0 = 1'b1;
    tick(2);
    bus.btn_s = 1'b1;
    tick(6);
    chk("t5_r0_pulse", int'(bus.r0_out), 1);
    tick(1);
    chk("t5_s_guard", int'(bus.s_out), 0);
    tick(1);
    chk("t5_s_idle", int'(bus.s_out), 0);
    tick(1);
    chk("t5_s_3_after_r0", int'(bus.s_out), 1);
    settle();
    chk("t5_s_pulses", s_cnt - b_s, 1);
    chk("t5_r0_pulses", r0_cnt - b_r0, 1);
`ifdef SR_CONFLICT_CNT_EN
    chk("t5_conflict", int'(bus.conflict_cnt), 1);
`endif

    // 6: reset during GUARD with set pending
    bus.btn_r0 = 1'b1;
    tick(2);
    bus.btn_s = 1'b1;
    tick(6);
    chk("t6_r0_pulse", int'(bus.r0_out), 1);
    tick(1);
    chk("t6_busy_guard", int'(bus.busy), 1);
    reset = 1'b1;
    bus.btn_s = 1'b0; bus.btn_r0 = 1'b0;
    #1;
    chk("t6_busy_in_reset", int'(bus.busy), 0);
    chk("t6_s_in_reset", int'(bus.s_out), 0);
    chk("t6_r0_in_reset", int'(bus.r0_out), 0);
`ifdef SR_CONFLICT_CNT_EN
    chk("t6_conflict_in_reset", int'(bus.conflict_cnt), 0);
`endif
    snap();
    tick(3);
    reset = 1'b0;
    tick(50);
    chk("t6_no_pulse_after", (s_cnt - b_s) + (r0_cnt - b_r0) + (r1_cnt - b_r1), 0);

`ifdef SR_CONFLICT_CNT_EN
    // Saturation of the dropped-set counter.
    for (int i = 0; i < 256; i++) begin
      bus.btn_s = 1'b1; bus.btn_r1 = 1'b1;
      tick(12);
      bus.btn_s = 1'b0; bus.btn_r1 = 1'b0;
      tick(12);
    end
    chk("sat_conflict", int'(bus.conflict_cnt), 255);
`endif

    chk("inv_no_overlap", overlap_cnt, 0);
    chk("inv_pulse_gap", gap_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
